// File: rtl/wbi_slave_port_node.sv
// wbi_slave_port_node
//   Terminal node of the interconnect daisy chain. Takes tid-tagged command
//   beats over valid/ready, runs the matching Wishbone single or burst cycle
//   on one slave, and returns every slave acknowledge (or error/timeout) as a
//   tid-tagged response beat through a one-entry response register.
// Ports:
//   mclk, reset_n         clock, asynchronous active-low reset
//   wbd_cmd_*             command beat in (valid/ready); adr/bl/tid/we taken
//                         from the first beat only
//   wbd_res_*             response beat out (valid/ready)
//   wbs_*                 Wishbone master side towards the slave
module wbi_slave_port_node #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned BW  = 4,
  parameter int unsigned BL  = 10,
  parameter int unsigned TOW = 8
) (
  input  logic          mclk,
  input  logic          reset_n,
  // command path
  output logic          wbd_cmd_wrdy_o,
  input  logic          wbd_cmd_wval_i,
  input  logic [AW-1:0] wbd_cmd_adr_i,
  input  logic          wbd_cmd_we_i,
  input  logic [DW-1:0] wbd_cmd_dat_i,
  input  logic [BW-1:0] wbd_cmd_sel_i,
  input  logic [3:0]    wbd_cmd_tid_i,
  input  logic [BL-1:0] wbd_cmd_bl_i,
  // response path
  input  logic          wbd_res_rrdy_i,
  output logic          wbd_res_rval_o,
  output logic [DW-1:0] wbd_res_dat_o,
  output logic          wbd_res_ack_o,
  output logic          wbd_res_lack_o,
  output logic          wbd_res_err_o,
  output logic [3:0]    wbd_res_tid_o,
  // Wishbone slave side
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic          wbs_we_o,
  output logic [AW-1:0] wbs_adr_o,
  output logic [DW-1:0] wbs_dat_o,
  output logic [BW-1:0] wbs_sel_o,
  output logic [BL-1:0] wbs_bl_o,
  output logic          wbs_bry_o,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_lack_i,
  input  logic          wbs_err_i
);

  localparam logic [BL-1:0]  REM_ONE  = BL'(1);
  // Timeout fires on the cycle whose increment would bring the timer to all-ones
  localparam logic [TOW-1:0] TMO_LAST = TOW'({TOW{1'b1}} - 1'b1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS   = 2'd1,
    S_WDATA = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            rdy_en_q;
  logic [AW-1:0]   adr_q, adr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [BW-1:0]   sel_q, sel_d;
  logic [3:0]      tid_q, tid_d;
  logic [BL-1:0]   bl_q, bl_d;
  logic [BL-1:0]   remain_q, remain_d;
  logic [TOW-1:0]  timer_q, timer_d;

  logic            rval_q, rval_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic            rack_q, rack_d;
  logic            rlack_q, rlack_d;
  logic            rerr_q, rerr_d;
  logic [3:0]      rtid_q, rtid_d;

  logic            free_c;
  logic            ack_c;
  logic            err_c;
  logic            lack_c;
  logic            accept_c;

  // Response register can take a new beat when empty or being drained now
  assign free_c   = ~rval_q | wbd_res_rrdy_i;
  assign ack_c    = free_c & wbs_ack_i;
  // Error beats out ack; timeout only loads once the response slot is free
  assign err_c    = free_c & (wbs_err_i | (timer_q == TMO_LAST));
  assign lack_c   = (remain_q == REM_ONE) | wbs_lack_i;
  assign accept_c = wbd_cmd_wval_i & wbd_cmd_wrdy_o;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    we_d     = we_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    tid_d    = tid_q;
    bl_d     = bl_q;
    remain_d = remain_q;
    timer_d  = timer_q;
    rval_d   = rval_q & ~wbd_res_rrdy_i;
    rdat_d   = rdat_q;
    rack_d   = rack_q;
    rlack_d  = rlack_q;
    rerr_d   = rerr_q;
    rtid_d   = rtid_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          adr_d    = wbd_cmd_adr_i;
          we_d     = wbd_cmd_we_i;
          dat_d    = wbd_cmd_dat_i;
          sel_d    = wbd_cmd_sel_i;
          tid_d    = wbd_cmd_tid_i;
          remain_d = (wbd_cmd_bl_i == '0) ? REM_ONE : wbd_cmd_bl_i;
          bl_d     = (wbd_cmd_bl_i == '0) ? REM_ONE : wbd_cmd_bl_i;
          timer_d  = '0;
          state_d  = S_BUS;
        end
      end

      S_BUS: begin
        if (err_c) begin
          rval_d  = 1'b1;
          rdat_d  = '0;
          rack_d  = 1'b0;
          rlack_d = 1'b1;
          rerr_d  = 1'b1;
          rtid_d  = tid_q;
          // Remaining write beats still arrive upstream and must be swallowed
          if (!we_q || (remain_q == REM_ONE)) begin
            state_d = S_IDLE;
          end else begin
            remain_d = remain_q - REM_ONE;
            state_d  = S_DRAIN;
          end
        end else if (ack_c) begin
          rval_d   = 1'b1;
          rdat_d   = wbs_dat_i;
          rack_d   = 1'b1;
          rlack_d  = lack_c;
          rerr_d   = 1'b0;
          rtid_d   = tid_q;
          remain_d = remain_q - REM_ONE;
          timer_d  = '0;
          if (lack_c)    state_d = S_IDLE;
          else if (we_q) state_d = S_WDATA;
        end else if (timer_q != TMO_LAST) begin
          timer_d = timer_q + TOW'(1);
        end
      end

      S_WDATA: begin
        if (accept_c) begin
          dat_d   = wbd_cmd_dat_i;
          sel_d   = wbd_cmd_sel_i;
          state_d = S_BUS;
        end
      end

      S_DRAIN: begin
        if (accept_c) begin
          remain_d = remain_q - REM_ONE;
          if (remain_q <= REM_ONE) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rdy_en_q <= 1'b0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      sel_q    <= '0;
      tid_q    <= '0;
      bl_q     <= '0;
      remain_q <= '0;
      timer_q  <= '0;
      rval_q   <= 1'b0;
      rdat_q   <= '0;
      rack_q   <= 1'b0;
      rlack_q  <= 1'b0;
      rerr_q   <= 1'b0;
      rtid_q   <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      adr_q    <= adr_d;
      we_q     <= we_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      tid_q    <= tid_d;
      bl_q     <= bl_d;
      remain_q <= remain_d;
      timer_q  <= timer_d;
      rval_q   <= rval_d;
      rdat_q   <= rdat_d;
      rack_q   <= rack_d;
      rlack_q  <= rlack_d;
      rerr_q   <= rerr_d;
      rtid_q   <= rtid_d;
    end
  end

  // Ready is held low while reset is applied and for the first cycle after it
  assign wbd_cmd_wrdy_o = rdy_en_q & (state_q != S_BUS);

  assign wbd_res_rval_o = rval_q;
  assign wbd_res_dat_o  = rdat_q;
  assign wbd_res_ack_o  = rack_q;
  assign wbd_res_lack_o = rlack_q;
  assign wbd_res_err_o  = rerr_q;
  assign wbd_res_tid_o  = rtid_q;

  // Strobe only when the response slot can absorb the resulting ack
  assign wbs_cyc_o = (state_q == S_BUS) | (state_q == S_WDATA);
  assign wbs_stb_o = (state_q == S_BUS) & free_c;
  assign wbs_bry_o = (state_q == S_BUS) & free_c;
  assign wbs_we_o  = we_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = dat_q;
  assign wbs_sel_o = sel_q;
  assign wbs_bl_o  = bl_q;

endmodule
